// File: rtl/pll_lock_reset_ctrl.sv
// Sequences the ECP5 PLL reset, qualifies its LOCK output for a stable window,
// and only then releases the downstream system reset; retries on timeout or lock loss.
module pll_lock_reset_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] relock_count
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic          sync_meta_r;
  logic          lock_s;
  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          cnt_hold_s;
  logic          timeout_s;
  logic [7:0]    relock_s;

  // Two-flop synchronizer for the asynchronous PLL LOCK output.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_r <= 1'b0;
      lock_s      <= 1'b0;
    end else begin
      sync_meta_r <= pll_locked;
      lock_s      <= sync_meta_r;
    end
  end

  // Next-state, counter and status computation.
  always_comb begin
    state_s    = state_r;
    cnt_hold_s = 1'b0;
    timeout_s  = timeout_err;
    relock_s   = relock_count;
    case (state_r)
      PLL_RESET: begin
        // restart is deliberately not looked at here: the pulse always completes
        if (cnt_r == RST_LAST) begin
          state_s = WAIT_LOCK;
        end else begin
          state_s = PLL_RESET;
        end
      end
      WAIT_LOCK: begin
        if (restart) begin
          state_s   = PLL_RESET;
          timeout_s = 1'b0;
        end else if (lock_s) begin
          state_s = STABLE;
        end else if (cnt_r == TMO_LAST) begin
          state_s   = PLL_RESET;
          timeout_s = 1'b1;
        end else begin
          state_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (restart) begin
          state_s   = PLL_RESET;
          timeout_s = 1'b0;
        end else if (!lock_s) begin
          state_s = WAIT_LOCK;
        end else if (cnt_r == STB_LAST) begin
          state_s = RUN;
        end else begin
          state_s = STABLE;
        end
      end
      RUN: begin
        if (restart) begin
          state_s   = PLL_RESET;
          timeout_s = 1'b0;
        end else if (!lock_s) begin
          state_s = PLL_RESET;
          if (relock_count != 8'hFF) begin
            relock_s = relock_count + 8'd1;
          end else begin
            relock_s = relock_count;
          end
        end else begin
          state_s    = RUN;
          cnt_hold_s = 1'b1;
        end
      end
      default: begin
        state_s = PLL_RESET;
      end
    endcase

    if (state_s != state_r) begin
      cnt_s = CNT_ZERO;
    end else if (cnt_hold_s) begin
      cnt_s = cnt_r;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // State register with outputs decoded from the next state so they move with it.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= PLL_RESET;
      cnt_r        <= CNT_ZERO;
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      timeout_err  <= 1'b0;
      relock_count <= 8'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pll_rst      <= (state_s == PLL_RESET);
      sys_rst_n    <= (state_s == RUN);
      ready        <= (state_s == RUN);
      timeout_err  <= timeout_s;
      relock_count <= relock_s;
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Scoreboard bench for pll_lock_reset_ctrl: stimulus queues expected output
// snapshots keyed by clock edge, a negedge monitor pops and compares them.
module tb_pll_lock_reset_ctrl;

  logic       clkin;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       timeout_err;
  logic [7:0] relock_count;

  pll_lock_reset_ctrl #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .restart     (restart),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .timeout_err (timeout_err),
    .relock_count(relock_count)
  );

  typedef struct {
    int          due;
    string       name;
    logic [11:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due at this cycle.
  always @(negedge clkin) begin
    logic [11:0] act;
    exp_t        e;
    act = {pll_rst, sys_rst_n, ready, timeout_err, relock_count};
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got {rst,srn,rdy,tmo,cnt}=%b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
                 e.name, cyc, act[11], act[10], act[9], act[8], act[7:0],
                 e.exp[11], e.exp[10], e.exp[9], e.exp[8], e.exp[7:0]);
      end
    end
  end

  function automatic void expect_at(input int due, input string nm, input logic pr,
                                    input logic srn, input logic rdy, input logic te,
                                    input logic [7:0] rc);
    exp_t e;
    e.due  = due;
    e.name = nm;
    e.exp  = {pr, srn, rdy, te, rc};
    sb.push_back(e);
  endfunction

  task automatic adv(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // One lock loss out of RUN followed by relock; k is the loss index since reset.
  task automatic loss(input int k, input bit detail);
    int c;
    logic [7:0] rc;
    logic [7:0] rcp;
    rc  = (k > 255) ? 8'd255 : 8'(k);
    rcp = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
    c = cyc;
    pll_locked = 1'b0;
    if (detail) begin
      expect_at(c + 2, "loss_still_run", 1'b0, 1'b1, 1'b1, 1'b0, rcp);
      expect_at(c + 3, "loss_reset", 1'b1, 1'b0, 1'b0, 1'b0, rc);
      expect_at(c + 6, "loss_pulse_end", 1'b1, 1'b0, 1'b0, 1'b0, rc);
      expect_at(c + 7, "loss_wait", 1'b0, 1'b0, 1'b0, 1'b0, rc);
      expect_at(c + 15, "loss_pre_run", 1'b0, 1'b0, 1'b0, 1'b0, rc);
    end
    expect_at(c + 16, "loss_relock_run", 1'b0, 1'b1, 1'b1, 1'b0, rc);
    adv(4);
    pll_locked = 1'b1;
    adv(13);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c, d, r, s, a;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;

    // Power-up
    adv(2);
    b = cyc;
    expect_at(b, "reset_state", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    adv(1);
    rst_n = 1'b1;
    b = cyc;
    expect_at(b + 3, "pup_pll_rst_hi", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(b + 4, "pup_pll_rst_lo", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    adv(10);
    pll_locked = 1'b1;
    expect_at(b + 20, "pup_pre_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(b + 21, "pup_run", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    adv(12);

    // First lock loss in detail
    loss(1, 1'b1);

    // Timeout retries, with a restart during PLL_RESET that must be ignored
    c = cyc;
    pll_locked = 1'b0;
    expect_at(c + 3, "tmo_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(c + 7, "tmo_wait", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(c + 38, "tmo_last_wait", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(c + 39, "tmo_first_retry", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(c + 42, "tmo_retry_pulse", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(c + 43, "tmo_retry_wait", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(c + 74, "tmo_second_wait", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(c + 75, "tmo_second_retry", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(c + 76, "restart_in_reset", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(c + 78, "restart_pulse_len", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(c + 79, "restart_pulse_end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    adv(75);
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
    adv(3);

    // Lock glitch in STABLE
    d = cyc;
    pll_locked = 1'b1;
    expect_at(d + 9, "glitch_stable", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(d + 11, "glitch_no_release", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(d + 18, "glitch_pre_run", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    expect_at(d + 19, "glitch_relock_run", 1'b0, 1'b1, 1'b1, 1'b1, 8'd2);
    adv(7);
    pll_locked = 1'b0;
    adv(1);
    pll_locked = 1'b1;
    adv(11);

    // Restart in RUN clears timeout_err, keeps relock_count
    r = cyc;
    expect_at(r, "restart_pre", 1'b0, 1'b1, 1'b1, 1'b1, 8'd2);
    restart = 1'b1;
    expect_at(r + 1, "restart_run", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(r + 4, "restart_pulse", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(r + 5, "restart_wait", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(r + 13, "restart_pre_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(r + 14, "restart_relock", 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    adv(1);
    restart = 1'b0;
    adv(13);

    // Restart coinciding with lock loss: no increment
    s = cyc;
    pll_locked = 1'b0;
    expect_at(s + 2, "coinc_pre", 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    expect_at(s + 3, "coinc_no_incr", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(s + 7, "coinc_wait", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(s + 15, "coinc_pre_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(s + 16, "coinc_run", 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    adv(2);
    restart = 1'b1;
    adv(1);
    restart    = 1'b0;
    pll_locked = 1'b1;
    adv(13);

    // Repeated lock losses up to and past saturation
    for (int k = 3; k <= 300; k++) begin
      loss(k, (k >= 254 && k <= 256));
    end

    // Async reset mid-STABLE
    a = cyc;
    pll_locked = 1'b0;
    expect_at(a + 10, "pre_async_stable", 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
    adv(4);
    pll_locked = 1'b1;
    adv(7);
    #2;
    rst_n = 1'b0;
    expect_at(cyc, "async_stable", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    adv(2);
    rst_n = 1'b1;
    b = cyc;
    expect_at(b + 12, "post_rst_pre_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(b + 13, "post_rst_run", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    adv(15);

    // Async reset mid-RUN
    #2;
    rst_n = 1'b0;
    expect_at(cyc, "async_run", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    adv(2);
    rst_n = 1'b1;

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clkin);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_ctrl.md
# pll_lock_reset_ctrl

Consumer-side companion to the ECP5 `EHXPLLL` clock generator. It drives the PLL `RST` input, watches the asynchronous `LOCK` output, and requires lock to stay stable before releasing the system reset. On loss of lock it re-asserts reset and retries, with a timeout. It runs in the 100 MHz input-clock domain, the PLL reference, which stays valid while the PLL is unlocked.

## Interface
- `PLL_RST_CYCLES`, default 16: width of the `pll_rst` pulse in `clkin` cycles (≥1).
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 100000: cycles to wait for lock before retrying the PLL reset (≥1).
- Internal counter width: `$clog2` of the largest of the three parameters, plus 1.

Ports:
- `clkin` in 1: single clock, 100 MHz PLL reference.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `LOCK`, asynchronous to `clkin`.
- `restart` in 1: synchronous request to re-run the full sequence.
- `pll_rst` out 1: drives PLL `RST`, active high.
- `sys_rst_n` out 1: active-low reset for downstream logic.
- `ready` out 1: high when in RUN.
- `timeout_err` out 1: sticky; a lock timeout has occurred.
- `relock_count` out 8: count of lock losses seen in RUN, saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`; both flops reset to 0.
- States are PLL_RESET, WAIT_LOCK, STABLE and RUN. One shared counter `cnt` is cleared on every state change.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - `pll_rst` = 1 only in PLL_RESET.
  - `sys_rst_n` = 1 and `ready` = 1 only in RUN.
- PLL_RESET: leave for WAIT_LOCK when `cnt == PLL_RST_CYCLES-1`, otherwise increment `cnt`.
- WAIT_LOCK:
  - `lock_s` = 1: go to STABLE.
  - Else if `cnt == LOCK_TIMEOUT_CYCLES-1`: set `timeout_err`, go to PLL_RESET.
  - Else increment `cnt`.
  - If lock and timeout coincide, lock wins.
- STABLE:
  - `lock_s` = 0: return to WAIT_LOCK (the timeout window restarts).
  - Else if `cnt == LOCK_STABLE_CYCLES-1`: go to RUN.
  - Else increment `cnt`.
- RUN: `lock_s` = 0 sends the block to PLL_RESET and increments `relock_count`, saturating at 255.
- `restart` = 1 in WAIT_LOCK, STABLE or RUN:
  - Go to PLL_RESET and clear `timeout_err`.
  - `relock_count` is not incremented, even if lock loss happens in the same cycle.
  - `restart` in PLL_RESET is ignored; it neither restarts the pulse nor clears the flag.
- Reset values while `rst_n` = 0: state PLL_RESET, `cnt` = 0, `pll_rst` = 1, `sys_rst_n` = 0, `ready` = 0, `timeout_err` = 0, `relock_count` = 0.
- Reset asserted mid-sequence returns to these values immediately and asynchronously. `sys_rst_n` therefore drops without a clock edge.

## Timing
- `pll_rst` is high for exactly `PLL_RST_CYCLES` edges after `rst_n` deasserts, or after entry into PLL_RESET.
- Lock acquisition, with `pll_locked` rising and setup met before edge E:
  - `lock_s` = 1 after edge E+1.
  - STABLE is entered at edge E+2.
  - RUN is entered, and `sys_rst_n` rises, at edge E+2+`LOCK_STABLE_CYCLES`.
- Lock loss in RUN, with `pll_locked` falling before edge E:
  - `sys_rst_n` and `ready` fall at edge E+2.
  - `pll_rst` rises at the same edge.
  - `relock_count` updates at the same edge.
- Timeout: with no lock, PLL_RESET is re-entered exactly `LOCK_TIMEOUT_CYCLES` edges after WAIT_LOCK entry, and `timeout_err` rises on that edge.
- A lock glitch shorter than `LOCK_STABLE_CYCLES` never releases `sys_rst_n`.
- `sys_rst_n` never glitches high outside RUN.

## Test plan
Parameters for all scenarios: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32.

- **Power-up:** deassert `rst_n`, raise `pll_locked` 10 cycles later → `pll_rst` high for 4 cycles, `sys_rst_n` rises 10 edges after the `pll_locked` rise, `relock_count`=0, `timeout_err`=0.
- **Timeout retry:** hold `pll_locked`=0 → `pll_rst` high for 4 cycles, then low for 32 cycles, repeating. `timeout_err` goes to 1 on the first retry edge and stays 1. `sys_rst_n` stays 0.
- **Glitch:** in STABLE, drop `pll_locked` for 1 cycle at 5 cycles in → return to WAIT_LOCK, no release. A later steady lock releases 10 edges after its rise.
- **Lock loss:** in RUN, drop `pll_locked` → `sys_rst_n`=0 two edges later, `relock_count`=1, `pll_rst` pulse of 4 cycles. Repeat 300 times → `relock_count`=255.
- **Restart:** pulse `restart` in RUN with `timeout_err`=1 → PLL_RESET, `timeout_err`=0, `relock_count` unchanged. `restart` asserted in the same cycle as a lock drop → still no increment.
- **Async reset:** assert `rst_n`=0 mid-STABLE and mid-RUN → all outputs return to their reset values immediately, without a clock edge.
